uart_runner: RTL and testbench
==============================

// Module: uart_runner
// PURPOSE
// - UART byte-echo block: deserialises 8N1 frames on rx_i and retransmits each good byte on tx_o.
// - Top-level bring-up block between the FPGA UART pins and the ALU command path.
// - Exposes the received byte as a one-cycle strobe so later stages can tap the byte stream.
// PARAMETERS
// - CLKS_PER_BIT  default 280  clocks per UART bit, both RX and TX; must be >= 4.
// - FIFO_DEPTH    default 4    echo FIFO depth when UART_ECHO_FIFO_EN is defined; power of 2.
// PORTS
// - clk_i        in   1  single system clock; all logic is on the rising edge.
// - rst_ni       in   1  asynchronous reset, active-low.
// - rx_i         in   1  UART serial input; idles high; asynchronous to clk_i.
// - tx_o         out  1  UART serial output; idles high.
// - rx_valid_o   out  1  one-cycle pulse when a frame with a good stop bit completes.
// - rx_data_o    out  8  received byte; held until the next rx_valid_o pulse.
// - frame_err_o  out  1  one-cycle pulse when the stop bit samples low.
// - overflow_o   out  1  one-cycle pulse when a good byte is dropped because the echo path is full.
// - tx_busy_o    out  1  high while a TX frame is in progress.
// BEHAVIOUR
// - Reset values: tx_o=1, rx_valid_o=0, rx_data_o=8'h00, frame_err_o=0, overflow_o=0, tx_busy_o=0.
// - Reset also clears all FSMs, counters and the buffer.
// - Reset asserted mid-frame: tx_o returns to 1 immediately; any partial RX or TX frame is discarded.
// - RX synchroniser: rx_i passes through 2 flops, reset to 1. All RX decisions use the synchronised value.
// - RX FSM states: IDLE, START, DATA, STOP.
//   - IDLE->START: synchronised rx goes low.
//   - START: wait CLKS_PER_BIT/2 cycles, then sample.
//     - Sample 1: glitch; return to IDLE with no output.
//     - Sample 0: go to DATA.
//   - DATA: take 8 samples, CLKS_PER_BIT apart, LSB first.
//   - STOP: take 1 sample CLKS_PER_BIT later.
//     - Sample 1: pulse rx_valid_o and update rx_data_o.
//     - Sample 0: pulse frame_err_o only; rx_data_o is unchanged.
//   - STOP->IDLE in the cycle after the stop sample.
// - Echo buffer (macro off): a single holding register plus a full flag.
//   - A good byte sets the flag.
//   - If the flag is already set, overflow_o pulses and the new byte is dropped.
// - TX FSM states: IDLE, START, DATA, STOP.
//   - IDLE: when the buffer is non-empty, load the byte and clear the buffer entry.
//   - START, DATA and STOP each hold tx_o for exactly CLKS_PER_BIT cycles per bit.
//   - Frame order: 0, d[0]..d[7], 1.
//   - Total frame length: 10*CLKS_PER_BIT cycles.
//   - tx_busy_o is high from the start bit through the end of the stop bit.
// - Echo latency: tx_o falls exactly 2 clocks after the rx_valid_o cycle when TX is idle.
// - Back-to-back TX: the next frame may start the cycle after the previous stop bit ends.
// - Simultaneous events: a buffer write and a TX read in the same cycle are both honoured. Read-before-write: the write lands and there is no overflow.
// - Bit counters saturate never; wrap only via explicit state transitions.
// CONFIGURATION
// - UART_ECHO_FIFO_EN defined: the echo buffer is a FIFO_DEPTH-entry circular FIFO.
//   - Read/write pointers are one bit wider than the address, to separate full from empty.
//   - overflow_o pulses only on a write while full.
//   - Write-while-full with a same-cycle read is accepted.
// - UART_ECHO_FIFO_EN undefined: single holding register as described above.
//   - FIFO_DEPTH is ignored.
// TESTING
// - 0x41 ('A') at 280 clk/bit after 1000 idle clocks ->
//   - rx_valid_o pulses once with rx_data_o=0x41.
//   - tx_o shows 0,1,0,0,0,0,0,1,0,1 at 280 clk/bit, starting 2 clk after the pulse.
//   - No further activity through 80000 clocks.
// - rx_i low for 100 clk then high ->
//   - No rx_valid_o and no frame_err_o.
//   - tx_o stays 1.
// - Byte 0x5A with stop bit driven 0 ->
//   - frame_err_o pulses once.
//   - No rx_valid_o and no echo on tx_o.
// - Back-to-back 0x55 then 0xAA, no gap ->
//   - Both echoed in order.
//   - No overflow_o in either configuration.
// - Three frames back-to-back while TX is busy ->
//   - Macro off: third byte dropped, overflow_o pulses.
//   - Macro on: all three echoed.
// - rst_ni pulsed low mid-TX-frame ->
//   - tx_o=1 and tx_busy_o=0 asynchronously.
//   - Next 0x41 echoes correctly.

Source files
------------

// File: rtl/uart_runner.sv
// rtl/uart_runner.sv - UART 8N1 byte echo: receive on rx_i, retransmit each good byte on tx_o
//
// Purpose
//   Deserialises 8N1 frames arriving on rx_i. Each byte with a good stop bit is
//   strobed out on rx_valid_o/rx_data_o and queued for retransmission on tx_o.
//
// Optional feature macro: UART_ECHO_FIFO_EN
//   undefined : the echo path is one holding register plus a full flag.
//   defined   : the echo path is a FIFO_DEPTH-entry circular FIFO.
//
// Ports
//   clk_i        system clock; all logic is on the rising edge
//   rst_ni       asynchronous reset, active low
//   rx_i         UART serial input, idles high, asynchronous to clk_i
//   tx_o         UART serial output, idles high
//   rx_valid_o   one-cycle pulse when a frame with a good stop bit completes
//   rx_data_o    last good byte, held until the next rx_valid_o pulse
//   frame_err_o  one-cycle pulse when the stop bit samples low
//   overflow_o   one-cycle pulse when a good byte is dropped (echo path full)
//   tx_busy_o    high from the start bit through the end of the stop bit
module uart_runner #(
    parameter int CLKS_PER_BIT = 280,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       tx_busy_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 1) begin : g_bad_param
        $error("uart_runner: CLKS_PER_BIT must be >= 4 and FIFO_DEPTH >= 1");
    end

    // ------------------------------------------------------------------
    // RX input synchroniser; idle level is high so both flops reset to 1.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit in: a high line here means the start edge was a glitch.
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Echo buffer. Written from the registered rx_valid/rx_data, so a byte
    // reaches TX one clock after the strobe and tx_o falls one clock later.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic             wr_en;
    logic             rd_en;
    logic             buf_empty;
    logic             buf_full;
    logic [7:0]       rd_data;
    logic             tx_ready;
    logic             overflow_d;
    logic             overflow_q;

    // TX takes a byte when idle, or on the last stop-bit cycle so frames can abut.
    assign tx_ready   = (tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_END));
    assign wr_en      = rx_valid_q;
    assign rd_en      = tx_ready && !buf_empty;
    // A same-cycle read frees the slot, so only an unread full buffer drops.
    assign overflow_d = wr_en && buf_full && !rd_en;

`ifdef UART_ECHO_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign buf_empty = (wptr_q == rptr_q);
    assign buf_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_data   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en && !overflow_d) begin
                mem_q[wptr_q[AW-1:0]] <= rx_data_q;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_full_q;

    assign buf_empty = !hold_full_q;
    assign buf_full  = hold_full_q;
    assign rd_data   = hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (wr_en && !overflow_d) begin
            hold_q      <= rx_data_q;
            hold_full_q <= 1'b1;
        end else if (rd_en) begin
            hold_full_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: frame is 0, d[0]..d[7], 1, each bit CLKS_PER_BIT cycles.
    // ------------------------------------------------------------------
    logic [2:0] tx_bit_q;
    logic [7:0] tx_shift_q;
    logic       tx_q;
    logic       tx_busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else if (rd_en) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= '0;
            tx_shift_q <= rd_data;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q      <= 1'b1;
                    tx_busy_q <= 1'b0;
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    // The back-to-back case is taken by the rd_en branch above.
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_o        = tx_q;
    assign tx_busy_o   = tx_busy_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_runner.sv
// tb/tb_uart_runner.sv - directed table-driven bench for uart_runner
`timescale 1ns/1ps
module tb_uart_runner;

    localparam int CPB    = 16;
    localparam int NBURST = 40;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       tx;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       ferr;
    logic       ovf;
    logic       busy;

    always #5 clk = ~clk;

    uart_runner #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .tx_o        (tx),
        .rx_valid_o  (rx_valid),
        .rx_data_o   (rx_data),
        .frame_err_o (ferr),
        .overflow_o  (ovf),
        .tx_busy_o   (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Free-running cycle count and event monitors, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0, n_ferr = 0, n_ovf = 0, valid_cyc = 0;
    int busy_run = 0, busy_len = 0;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (ferr === 1'b1) n_ferr <= n_ferr + 1;
        if (ovf === 1'b1) n_ovf <= n_ovf + 1;
        if (busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            busy_len <= busy_run;
            busy_run <= 0;
        end
    end

    // Independent TX line decoder: mid-bit samples from the first low cycle.
    logic [7:0] tx_q [$];
    int tx_start_cyc = 0;
    int n_bad_stop   = 0;

    initial begin : tx_decoder
        int       t0;
        bit       ok;
        logic [9:0] bits;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t0   = cyc;
                ok   = 1'b1;
                bits = '0;
                for (int c = 1; c <= 9 * CPB + CPB / 2; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ok = 1'b0;
                    if (c % CPB == CPB / 2) bits[c / CPB] = tx;
                end
                if (ok) begin
                    tx_start_cyc = t0;
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) n_bad_stop++;
                    tx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    task automatic send_bit(logic v, int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, logic stop, int stop_len);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
        send_bit(stop, stop_len);
        rx = 1'b1;
    endtask

    typedef struct {
        int         glitch;
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        int         exp_echo;
        logic [7:0] exp_rx_data;
    } vec_t;

    initial begin
        vec_t       vecs [7];
        logic [7:0] sent [NBURST];
        int         nv, nf, no, nq, k, order_ok, echoed, drops, waited;

        vecs[0] = '{5,     8'h00, 1'b1, 0, 0, 0, 8'h41};
        vecs[1] = '{0,     8'h5A, 1'b0, 0, 1, 0, 8'h41};
        vecs[2] = '{0,     8'h00, 1'b1, 1, 0, 1, 8'h00};
        vecs[3] = '{0,     8'hFF, 1'b1, 1, 0, 1, 8'hFF};
        vecs[4] = '{0,     8'hA5, 1'b1, 1, 0, 1, 8'hA5};
        vecs[5] = '{0,     8'h80, 1'b1, 1, 0, 1, 8'h80};
        vecs[6] = '{0,     8'h01, 1'b0, 0, 1, 0, 8'h80};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", ferr, 0);
        check("rst_overflow", ovf, 0);
        check("rst_tx_busy", busy, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        // 0x41: strobe, echo latency, frame length, then quiet line
        nv = n_valid; nq = tx_q.size();
        send_frame(8'h41, 1'b1, CPB);
        repeat (11 * CPB) @(negedge clk);
        check("a_valid_cnt", n_valid - nv, 1);
        check("a_rx_data", rx_data, 8'h41);
        check("a_echo_cnt", tx_q.size() - nq, 1);
        if (tx_q.size() > nq) check("a_echo_byte", tx_q[$], 8'h41);
        check("a_latency", tx_start_cyc - valid_cyc, 2);
        check("a_busy_len", busy_len, 10 * CPB);
        nv = n_valid; nq = tx_q.size();
        repeat (60 * CPB) @(negedge clk);
        check("a_quiet_valid", n_valid - nv, 0);
        check("a_quiet_tx", tx_q.size() - nq, 0);
        check("a_quiet_line", tx, 1);

        // Table of single-frame vectors
        for (int i = 0; i < 7; i++) begin
            nv = n_valid; nf = n_ferr; no = n_ovf; nq = tx_q.size();
            if (vecs[i].glitch != 0) begin
                send_bit(1'b0, vecs[i].glitch);
                rx = 1'b1;
            end else begin
                send_frame(vecs[i].data, vecs[i].stop, CPB);
            end
            repeat (12 * CPB) @(negedge clk);
            check($sformatf("v%0d_valid", i), n_valid - nv, vecs[i].exp_valid);
            check($sformatf("v%0d_ferr", i), n_ferr - nf, vecs[i].exp_ferr);
            check($sformatf("v%0d_ovf", i), n_ovf - no, 0);
            check($sformatf("v%0d_echo_cnt", i), tx_q.size() - nq, vecs[i].exp_echo);
            if (vecs[i].exp_echo != 0 && tx_q.size() > nq)
                check($sformatf("v%0d_echo_byte", i), tx_q[$], vecs[i].data);
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx_data);
            check($sformatf("v%0d_line", i), tx, 1);
        end

        // Back-to-back 0x55, 0xAA
        nv = n_valid; no = n_ovf; nq = tx_q.size();
        send_frame(8'h55, 1'b1, CPB);
        send_frame(8'hAA, 1'b1, CPB);
        repeat (22 * CPB) @(negedge clk);
        check("b2b_echo_cnt", tx_q.size() - nq, 2);
        if (tx_q.size() >= nq + 2) begin
            check("b2b_first", tx_q[nq], 8'h55);
            check("b2b_second", tx_q[nq + 1], 8'hAA);
        end
        check("b2b_ovf", n_ovf - no, 0);

        // Burst with shortened stop bits: RX outpaces TX slowly
        nv = n_valid; no = n_ovf; nq = tx_q.size();
        for (int i = 0; i < NBURST; i++) begin
            sent[i] = 8'((i * 7 + 3) & 8'hFF);
            send_frame(sent[i], 1'b1, CPB / 2 + 2);
        end
        repeat (30 * CPB) @(negedge clk);
        echoed = tx_q.size() - nq;
        drops  = n_ovf - no;
        check("burst_valid_cnt", n_valid - nv, NBURST);
`ifdef UART_ECHO_FIFO_EN
        check("burst_drops", drops, 0);
        check("burst_echoed", echoed, NBURST);
`else
        check("burst_drop_seen", (drops > 0) ? 1 : 0, 1);
        check("burst_accounted", echoed + drops, NBURST);
`endif
        k = 0; order_ok = 1;
        for (int e = nq; e < tx_q.size(); e++) begin
            while (k < NBURST && sent[k] != tx_q[e]) k++;
            if (k == NBURST) order_ok = 0;
            else k++;
        end
        check("burst_order", order_ok, 1);

        // Reset pulsed mid-TX frame
        send_frame(8'h41, 1'b1, CPB);
        waited = 0;
        while (busy !== 1'b1 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
        end
        check("rstmid_busy_seen", busy, 1);
        repeat (3 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tx", tx, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_rx_data", rx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        nv = n_valid; nq = tx_q.size();
        send_frame(8'h41, 1'b1, CPB);
        repeat (11 * CPB) @(negedge clk);
        check("rstmid_valid", n_valid - nv, 1);
        check("rstmid_echo_cnt", tx_q.size() - nq, 1);
        if (tx_q.size() > nq) check("rstmid_echo_byte", tx_q[$], 8'h41);

        check("tx_framing", n_bad_stop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
